// File: rtl/byte_reg_pkg.sv
// Shared types and helpers for the byte-addressed register bank.
package byte_reg_pkg;

    typedef enum logic [1:0] {
        REG_RW  = 2'd0,
        REG_W1C = 2'd1,
        REG_RO  = 2'd2
    } reg_mode_t;

    localparam int BYTE_W = 8;

    // Number of register bits that live in a given byte lane (0 past the top).
    function automatic int lane_width(input int data_width, input int lane);
        int rem;
        rem = data_width - lane * BYTE_W;
        if (rem >= BYTE_W) begin
            return BYTE_W;
        end else if (rem > 0) begin
            return rem;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/byte_reg_bank_cell.sv
// Single register of the bank: masked write, write-one-to-clear with hardware set,
// or read-only mirror of a hardware value.
module byte_reg_cell
    import byte_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter logic [1:0]            MODE       = 2'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] hw_set,
    input  logic [DATA_WIDTH-1:0] hw_val,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] val_d;
    logic [DATA_WIDTH-1:0] clr;

    always_comb begin
        clr   = wr_en ? (wr_data & wr_mask) : '0;
        val_d = val_q;
        case (MODE)
            REG_RW:  val_d = wr_en ? ((val_q & ~wr_mask) | (wr_data & wr_mask)) : val_q;
            // A set in the same cycle as a clear leaves the bit set.
            REG_W1C: val_d = (val_q & ~clr) | hw_set;
            default: val_d = hw_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= INIT;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/byte_reg_bank.sv
// Byte-addressed register bank: address decode, optional staging, read-back and error flag.
// Define BYTE_REG_BANK_ATOMIC_EN to stage lower lanes and commit on the top-lane write.
module byte_reg_bank
    import byte_reg_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 4,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] INIT       = '0,
    parameter logic [2*NUM_REGS-1:0]          REG_MODE   = '0,
    localparam int BYTES  = (DATA_WIDTH + BYTE_W - 1) / BYTE_W,
    localparam int BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [IDX_W-1:0]               reg_idx,
    input  logic [BSEL_W-1:0]              byte_sel,
    input  logic [BYTE_W-1:0]              wr_data,
    output logic [BYTE_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           wr_err,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_val,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int EXT_W = BYTES * BYTE_W;

    logic              idx_ok;
    logic              lane_ok;
    logic [1:0]        mode_bits;
    logic              wr_ok;
    logic              wr_legal;
    logic [EXT_W-1:0]  lane_bits;
    logic [EXT_W-1:0]  wr_ext;
    logic [BYTE_W-1:0] rd_byte;

    logic                  cmt_en;
    logic [IDX_W-1:0]      cmt_idx;
    logic [DATA_WIDTH-1:0] cmt_mask;
    logic [DATA_WIDTH-1:0] cmt_data;

    logic [BYTE_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              wr_err_q;

    always_comb begin
        idx_ok    = 1'b0;
        mode_bits = 2'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_idx == IDX_W'(i)) begin
                idx_ok    = 1'b1;
                mode_bits = REG_MODE[2*i +: 2];
            end
        end
    end

    always_comb begin
        lane_ok   = 1'b0;
        lane_bits = '0;
        for (int l = 0; l < BYTES; l++) begin
            if (byte_sel == BSEL_W'(l)) begin
                lane_ok = 1'b1;
                lane_bits[l*BYTE_W +: BYTE_W] = 8'hFF >> (BYTE_W - lane_width(DATA_WIDTH, l));
            end
        end
    end

    // Encodings 2 and 3 are both read-only.
    assign wr_ok    = idx_ok & lane_ok & ~mode_bits[1];
    assign wr_legal = wr_en & wr_ok;
    assign wr_ext   = {BYTES{wr_data}};

`ifdef BYTE_REG_BANK_ATOMIC_EN
    logic [IDX_W-1:0] stg_idx_q, stg_idx_d;
    logic [EXT_W-1:0] stg_mask_q, stg_mask_d;
    logic [EXT_W-1:0] stg_data_q, stg_data_d;
    logic             top_lane;
    logic             same_reg;
    logic [EXT_W-1:0] merge_mask;
    logic [EXT_W-1:0] merge_data;

    assign top_lane = (byte_sel == BSEL_W'(BYTES - 1));
    assign same_reg = (stg_idx_q == reg_idx);

    always_comb begin
        stg_idx_d  = stg_idx_q;
        stg_mask_d = stg_mask_q;
        stg_data_d = stg_data_q;
        merge_mask = lane_bits;
        merge_data = wr_ext & lane_bits;
        if (same_reg) begin
            merge_mask = stg_mask_q | lane_bits;
            merge_data = (stg_data_q & ~lane_bits) | (wr_ext & lane_bits);
        end
        cmt_en   = 1'b0;
        cmt_idx  = reg_idx;
        cmt_mask = merge_mask[DATA_WIDTH-1:0];
        cmt_data = merge_data[DATA_WIDTH-1:0];
        if (wr_legal) begin
            if (top_lane) begin
                cmt_en     = 1'b1;
                stg_mask_d = '0;
                stg_data_d = '0;
            end else begin
                // Staged bytes of another register are dropped, not merged.
                stg_idx_d  = reg_idx;
                stg_mask_d = merge_mask;
                stg_data_d = merge_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_idx_q  <= '0;
            stg_mask_q <= '0;
            stg_data_q <= '0;
        end else begin
            stg_idx_q  <= stg_idx_d;
            stg_mask_q <= stg_mask_d;
            stg_data_q <= stg_data_d;
        end
    end
`else
    always_comb begin
        cmt_en   = wr_legal;
        cmt_idx  = reg_idx;
        cmt_mask = lane_bits[DATA_WIDTH-1:0];
        cmt_data = wr_ext[DATA_WIDTH-1:0];
    end
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        byte_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .INIT       (INIT[i*DATA_WIDTH +: DATA_WIDTH]),
            .MODE       (REG_MODE[2*i +: 2])
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (cmt_en && (cmt_idx == IDX_W'(i))),
            .wr_mask (cmt_mask),
            .wr_data (cmt_data),
            .hw_set  (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
            .hw_val  (hw_val[i*DATA_WIDTH +: DATA_WIDTH]),
            .q       (regs_out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Reads see committed values only; unmatched addresses return zero.
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int l = 0; l < BYTES; l++) begin
                if (reg_idx == IDX_W'(i) && byte_sel == BSEL_W'(l)) begin
                    rd_byte = BYTE_W'(regs_out[i*DATA_WIDTH +: DATA_WIDTH] >> (BYTE_W * l));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            wr_err_q   <= wr_en & ~wr_ok;
            if (rd_en) begin
                rd_data_q <= rd_byte;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_byte_reg_bank.sv
// Scoreboard bench for byte_reg_bank: a 32-bit/4-register bank and a 12-bit/3-register bank.
module tb_byte_reg_bank;

    localparam int AW = 32;
    localparam int AN = 4;
    localparam int BW = 12;
    localparam int BN = 3;
    localparam logic [AN*AW-1:0] A_INIT = {32'hCAFEF00D, 96'h0};
    localparam logic [2*AN-1:0]  A_MODE = 8'h24;   // reg1 W1C, reg2 RO
    localparam logic [BN*BW-1:0] B_INIT = {24'h0, 12'hABC};

`ifdef BYTE_REG_BANK_ATOMIC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             a_rst_n, a_wr_en, a_rd_en;
    logic [1:0]       a_idx, a_sel;
    logic [7:0]       a_wdata, a_rdata;
    logic             a_rd_valid, a_wr_err;
    logic [AN*AW-1:0] a_hw_set, a_hw_val, a_regs;

    logic             b_rst_n, b_wr_en, b_rd_en;
    logic [1:0]       b_idx;
    logic [0:0]       b_sel;
    logic [7:0]       b_wdata, b_rdata;
    logic             b_rd_valid, b_wr_err;
    logic [BN*BW-1:0] b_hw_set, b_hw_val, b_regs;

    byte_reg_bank #(.DATA_WIDTH(AW), .NUM_REGS(AN), .INIT(A_INIT), .REG_MODE(A_MODE)) u_a (
        .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .rd_en(a_rd_en), .reg_idx(a_idx),
        .byte_sel(a_sel), .wr_data(a_wdata), .rd_data(a_rdata), .rd_valid(a_rd_valid),
        .wr_err(a_wr_err), .hw_set(a_hw_set), .hw_val(a_hw_val), .regs_out(a_regs)
    );

    byte_reg_bank #(.DATA_WIDTH(BW), .NUM_REGS(BN), .INIT(B_INIT), .REG_MODE(6'h0)) u_b (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .rd_en(b_rd_en), .reg_idx(b_idx),
        .byte_sel(b_sel), .wr_data(b_wdata), .rd_data(b_rdata), .rd_valid(b_rd_valid),
        .wr_err(b_wr_err), .hw_set(b_hw_set), .hw_val(b_hw_val), .regs_out(b_regs)
    );

    int total  = 0;
    int passed = 0;

    logic [7:0] a_exp_rd[$];
    logic [7:0] b_exp_rd[$];
    bit         a_exp_err[$];
    bit         b_exp_err[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (a_rd_valid) begin
            if (a_exp_rd.size() == 0) begin
                total++;
                $display("FAIL a_rd_unexpected: got rd_valid with data 0x%0h, expected none", a_rdata);
            end else chk("a_rd_data", 64'(a_rdata), 64'(a_exp_rd.pop_front()));
        end
        if (a_wr_err) begin
            if (a_exp_err.size() == 0) begin
                total++;
                $display("FAIL a_wr_err_unexpected: got 1 expected 0");
            end else chk("a_wr_err", 64'(a_wr_err), 64'(a_exp_err.pop_front()));
        end
        if (b_rd_valid) begin
            if (b_exp_rd.size() == 0) begin
                total++;
                $display("FAIL b_rd_unexpected: got rd_valid with data 0x%0h, expected none", b_rdata);
            end else chk("b_rd_data", 64'(b_rdata), 64'(b_exp_rd.pop_front()));
        end
        if (b_wr_err) begin
            if (b_exp_err.size() == 0) begin
                total++;
                $display("FAIL b_wr_err_unexpected: got 1 expected 0");
            end else chk("b_wr_err", 64'(b_wr_err), 64'(b_exp_err.pop_front()));
        end
    end

    task automatic a_op(input bit we, input bit re, input logic [1:0] idx, input logic [1:0] sel,
                        input logic [7:0] d, input logic [7:0] exp, input bit bad);
        @(negedge clk);
        a_wr_en = we; a_rd_en = re; a_idx = idx; a_sel = sel; a_wdata = d;
        if (re) a_exp_rd.push_back(exp);
        if (we && bad) a_exp_err.push_back(1'b1);
        @(negedge clk);
        a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic b_op(input bit we, input bit re, input logic [1:0] idx, input logic [0:0] sel,
                        input logic [7:0] d, input logic [7:0] exp, input bit bad);
        @(negedge clk);
        b_wr_en = we; b_rd_en = re; b_idx = idx; b_sel = sel; b_wdata = d;
        if (re) b_exp_rd.push_back(exp);
        if (we && bad) b_exp_err.push_back(1'b1);
        @(negedge clk);
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    initial begin
        a_rst_n = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_idx = '0; a_sel = '0; a_wdata = '0;
        a_hw_set = '0;
        a_hw_val = '0;
        a_hw_val[64 +: 32] = 32'h12345678;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_idx = '0; b_sel = '0; b_wdata = '0;
        b_hw_set = '0; b_hw_val = '0;

        repeat (2) @(negedge clk);
        chk("a_reset_regs", 64'(a_regs[63:0]), 64'h0);
        chk("a_reset_reg3", 64'(a_regs[96 +: 32]), 64'hCAFEF00D);
        chk("a_reset_rdata", 64'(a_rdata), 64'h0);
        chk("a_reset_rvalid", 64'(a_rd_valid), 64'h0);
        chk("a_reset_wr_err", 64'(a_wr_err), 64'h0);
        a_rst_n = 1'b1;
        @(negedge clk);
        chk("a_ro_mirror", 64'(a_regs[64 +: 32]), 64'h12345678);

        // RW byte writes
        a_op(1, 0, 2'd0, 2'd0, 8'hAA, 8'h00, 0);
        chk("a_rw_lane0", 64'(a_regs[0 +: 32]), ATOMIC ? 64'h0 : 64'hAA);
        a_op(1, 0, 2'd0, 2'd3, 8'h55, 8'h00, 0);
        chk("a_rw_lane3", 64'(a_regs[0 +: 32]), 64'h550000AA);
        a_op(0, 1, 2'd0, 2'd3, 8'h00, 8'h55, 0);

        // RO write rejected, read back mirror
        a_op(1, 0, 2'd2, 2'd0, 8'hFF, 8'h00, 1);
        chk("a_ro_unchanged", 64'(a_regs[64 +: 32]), 64'h12345678);
        a_op(0, 1, 2'd2, 2'd1, 8'h00, 8'h56, 0);

        // W1C: set wins over same-cycle clear, then clear alone
        a_hw_set[32] = 1'b1;
        @(negedge clk);
        chk("a_w1c_set", 64'(a_regs[32 +: 32]), 64'h1);
        a_op(1, 0, 2'd1, 2'd0, 8'h01, 8'h00, 0);
        if (ATOMIC) a_op(1, 0, 2'd1, 2'd3, 8'h00, 8'h00, 0);
        chk("a_w1c_collision", 64'(a_regs[32 +: 32]), 64'h1);
        a_hw_set[32] = 1'b0;
        a_op(1, 0, 2'd1, 2'd0, 8'h01, 8'h00, 0);
        if (ATOMIC) begin
            chk("a_w1c_staged", 64'(a_regs[32 +: 32]), 64'h1);
            a_op(1, 0, 2'd1, 2'd3, 8'h00, 8'h00, 0);
        end
        chk("a_w1c_clear", 64'(a_regs[32 +: 32]), 64'h0);

        // Simultaneous read and write returns the pre-write committed value
        a_op(1, 1, 2'd3, 2'd0, 8'h11, 8'h0D, 0);
        chk("a_rdwr_reg3", 64'(a_regs[96 +: 32]), ATOMIC ? 64'hCAFEF00D : 64'hCAFEF011);
        a_op(0, 1, 2'd3, 2'd0, 8'h00, ATOMIC ? 8'h0D : 8'h11, 0);

        // Multi-byte sequence: commit, then a restart by another register
        a_op(1, 0, 2'd0, 2'd0, 8'h11, 8'h00, 0);
        a_op(1, 0, 2'd0, 2'd1, 8'h22, 8'h00, 0);
        a_op(1, 0, 2'd0, 2'd2, 8'h33, 8'h00, 0);
        chk("a_stage3", 64'(a_regs[0 +: 32]), ATOMIC ? 64'h550000AA : 64'h55332211);
        a_op(1, 0, 2'd0, 2'd3, 8'h44, 8'h00, 0);
        chk("a_commit", 64'(a_regs[0 +: 32]), 64'h44332211);
        a_op(1, 0, 2'd0, 2'd0, 8'h99, 8'h00, 0);
        a_op(1, 0, 2'd1, 2'd0, 8'h00, 8'h00, 0);
        a_op(1, 0, 2'd0, 2'd3, 8'h66, 8'h00, 0);
        chk("a_restart", 64'(a_regs[0 +: 32]), ATOMIC ? 64'h66332211 : 64'h66332299);

        // Narrow 12-bit bank
        repeat (2) @(negedge clk);
        chk("b_reset_regs", 64'(b_regs), 64'(B_INIT));
        b_rst_n = 1'b1;
        b_op(1, 1, 2'd3, 1'd0, 8'h55, 8'h00, 1);
        chk("b_oob_unchanged", 64'(b_regs), 64'(B_INIT));
        b_op(1, 0, 2'd1, 1'd1, 8'hFF, 8'h00, 0);
        chk("b_narrow_top", 64'(b_regs[12 +: 12]), 64'hF00);
        b_op(0, 1, 2'd1, 1'd1, 8'h00, 8'h0F, 0);
        b_op(0, 1, 2'd0, 1'd1, 8'h00, 8'h0A, 0);

        // Reset with a lower lane pending
        b_op(1, 0, 2'd0, 1'd0, 8'h77, 8'h00, 0);
        chk("b_lane0", 64'(b_regs[0 +: 12]), ATOMIC ? 64'hABC : 64'hA77);
        b_rst_n = 1'b0;
        @(negedge clk);
        chk("b_midreset_regs", 64'(b_regs), 64'(B_INIT));
        chk("b_midreset_rdata", 64'(b_rdata), 64'h0);
        b_rst_n = 1'b1;
        b_op(1, 0, 2'd0, 1'd1, 8'h05, 8'h00, 0);
        chk("b_after_reset", 64'(b_regs[0 +: 12]), 64'h5BC);

        repeat (3) @(negedge clk);
        chk("a_rd_pending", 64'(a_exp_rd.size()), 64'h0);
        chk("a_err_pending", 64'(a_exp_err.size()), 64'h0);
        chk("b_rd_pending", 64'(b_exp_rd.size()), 64'h0);
        chk("b_err_pending", 64'(b_exp_err.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
